// File: rtl/msrv32_instr_queue_if.sv
// Instruction queue bus: producer-side push port, decode-side pop port and
// the decoded field view of the presented word.
interface msrv32_instr_queue_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) ();

  logic                     flush_in;
  logic [31:0]              ms_riscv32_mp_instr_in;
  logic [PC_W-1:0]          pc_in;
  logic                     instr_valid_in;
  logic                     instr_ready_out;
  logic                     dec_valid_out;
  logic                     dec_ready_in;
  logic [6:0]               opcode_out;
  logic [2:0]               funct3_out;
  logic [6:0]               funct7_out;
  logic [4:0]               rs1addr_out;
  logic [4:0]               rs2addr_out;
  logic [4:0]               rdaddr_out;
  logic [11:0]              csr_addr_out;
  logic [24:0]              instr_out;
  logic [PC_W-1:0]          pc_out;
  logic [$clog2(DEPTH):0]   count_out;

  // Fetch/decode side: drives the word stream and consumes the head.
  modport master (
    output flush_in, ms_riscv32_mp_instr_in, pc_in, instr_valid_in, dec_ready_in,
    input  instr_ready_out, dec_valid_out, opcode_out, funct3_out, funct7_out,
           rs1addr_out, rs2addr_out, rdaddr_out, csr_addr_out, instr_out,
           pc_out, count_out
  );

  // Queue side.
  modport slave (
    input  flush_in, ms_riscv32_mp_instr_in, pc_in, instr_valid_in, dec_ready_in,
    output instr_ready_out, dec_valid_out, opcode_out, funct3_out, funct7_out,
           rs1addr_out, rs2addr_out, rdaddr_out, csr_addr_out, instr_out,
           pc_out, count_out
  );

endinterface

// File: rtl/msrv32_instr_queue.sv
// Instruction queue between fetch and decode. Words are tagged with their PC
// and held in a small circular buffer; the head is presented already split
// into RISC-V fields. A flushed or empty queue presents a NOP.
module msrv32_instr_queue #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] NOP_INSTR = 32'h00000013,
  parameter int          PC_W      = 32
) (
  input  logic                 ms_riscv32_mp_clk_in,
  input  logic                 ms_riscv32_mp_rst_in,
  msrv32_instr_queue_if.slave  q
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if ((DEPTH < 2) || (DEPTH > 16) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("msrv32_instr_queue: DEPTH must be a power of 2 between 2 and 16");
  end

  logic [31:0]     mem_instr [DEPTH];
  logic [PC_W-1:0] mem_pc    [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [CW-1:0]   count;

  logic            full;
  logic            ready;
  logic            valid;
  logic            push;
  logic            pop;
  logic [31:0]     word;

  // Ready depends only on registered occupancy so a full queue never takes a
  // word, even when decode drains the head in the same cycle.
  always_comb begin
    full  = (count == CW'(DEPTH));
    ready = ~full;
    valid = (count != '0) && !q.flush_in;
    push  = q.instr_valid_in && ready && !q.flush_in;
    pop   = valid && q.dec_ready_in;
  end

  // Storage has no reset; only the tail slot is written on a push.
  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (push) begin
      mem_instr[tail] <= q.ms_riscv32_mp_instr_in;
      mem_pc[tail]    <= q.pc_in;
    end
  end

  // Pointer and occupancy update; flush discards any same-cycle push/pop.
  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (q.flush_in) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + AW'(1);
      if (pop)  head <= head + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Presented word and its field slices; no bypass from the push port.
  always_comb begin
    word           = valid ? mem_instr[head] : NOP_INSTR;
    q.opcode_out   = word[6:0];
    q.rdaddr_out   = word[11:7];
    q.funct3_out   = word[14:12];
    q.rs1addr_out  = word[19:15];
    q.rs2addr_out  = word[24:20];
    q.funct7_out   = word[31:25];
    q.csr_addr_out = word[31:20];
    q.instr_out    = word[31:7];
    q.pc_out       = valid ? mem_pc[head] : '0;
  end

  // Handshake and occupancy outputs.
  always_comb begin
    q.instr_ready_out = ready;
    q.dec_valid_out   = valid;
    q.count_out       = count;
  end

endmodule

// File: tb/tb_msrv32_instr_queue.sv
// Scoreboard bench for msrv32_instr_queue: a DEPTH=4 and a DEPTH=2 instance.
module tb_msrv32_instr_queue;

  typedef struct packed {
    logic [31:0] w;
    logic [31:0] pc;
  } ent_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;
  ent_t exp4[$];
  ent_t exp2[$];
  ent_t e4, e2;

  always #5 clk = ~clk;

  msrv32_instr_queue_if #(.DEPTH(4), .PC_W(32)) i4 ();
  msrv32_instr_queue_if #(.DEPTH(2), .PC_W(32)) i2 ();

  msrv32_instr_queue #(.DEPTH(4), .NOP_INSTR(32'h00000013), .PC_W(32)) dut4 (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .q                    (i4)
  );

  msrv32_instr_queue #(.DEPTH(2), .NOP_INSTR(32'h00000013), .PC_W(32)) dut2 (
    .ms_riscv32_mp_clk_in (clk),
    .ms_riscv32_mp_rst_in (rst_n),
    .q                    (i2)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  task automatic chk_pop(input string tag, input ent_t e, input logic [6:0] op,
                         input logic [2:0] f3, input logic [6:0] f7,
                         input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic [4:0] rd, input logic [11:0] csr,
                         input logic [24:0] ins, input logic [31:0] pc);
    chk({tag, "_word"},   {ins, op}, e.w);
    chk({tag, "_funct3"}, f3,  e.w[14:12]);
    chk({tag, "_funct7"}, f7,  e.w[31:25]);
    chk({tag, "_rs1"},    rs1, e.w[19:15]);
    chk({tag, "_rs2"},    rs2, e.w[24:20]);
    chk({tag, "_rd"},     rd,  e.w[11:7]);
    chk({tag, "_csr"},    csr, e.w[31:20]);
    chk({tag, "_pc"},     pc,  e.pc);
  endtask

  // Monitors: every accepted pop is compared against the scoreboard head.
  always @(negedge clk) begin
    if (i4.dec_valid_out && i4.dec_ready_in) begin
      if (exp4.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL pop4_extra: got word %h, required no entry", {i4.instr_out, i4.opcode_out});
      end else begin
        e4 = exp4.pop_front();
        chk_pop("pop4", e4, i4.opcode_out, i4.funct3_out, i4.funct7_out, i4.rs1addr_out,
                i4.rs2addr_out, i4.rdaddr_out, i4.csr_addr_out, i4.instr_out, i4.pc_out);
      end
    end
  end

  always @(negedge clk) begin
    if (i2.dec_valid_out && i2.dec_ready_in) begin
      if (exp2.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL pop2_extra: got word %h, required no entry", {i2.instr_out, i2.opcode_out});
      end else begin
        e2 = exp2.pop_front();
        chk_pop("pop2", e2, i2.opcode_out, i2.funct3_out, i2.funct7_out, i2.rs1addr_out,
                i2.rs2addr_out, i2.rdaddr_out, i2.csr_addr_out, i2.instr_out, i2.pc_out);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic push4(input logic [31:0] w, input logic [31:0] pc, input logic acc);
    i4.instr_valid_in = 1'b1;
    i4.ms_riscv32_mp_instr_in = w;
    i4.pc_in = pc;
    if (acc) exp4.push_back({w, pc});
    @(negedge clk);
    chk("ready4", i4.instr_ready_out, acc);
    step();
    i4.instr_valid_in = 1'b0;
  endtask

  task automatic pop4();
    i4.dec_ready_in = 1'b1;
    step();
    i4.dec_ready_in = 1'b0;
  endtask

  task automatic push2(input logic [31:0] w, input logic [31:0] pc);
    i2.instr_valid_in = 1'b1;
    i2.ms_riscv32_mp_instr_in = w;
    i2.pc_in = pc;
    exp2.push_back({w, pc});
    @(negedge clk);
    chk("ready2_fill", i2.instr_ready_out, 1'b1);
    step();
    i2.instr_valid_in = 1'b0;
  endtask

  initial begin
    i4.flush_in = 0; i4.ms_riscv32_mp_instr_in = 0; i4.pc_in = 0;
    i4.instr_valid_in = 0; i4.dec_ready_in = 0;
    i2.flush_in = 0; i2.ms_riscv32_mp_instr_in = 0; i2.pc_in = 0;
    i2.instr_valid_in = 0; i2.dec_ready_in = 0;

    // Reset state
    #12;
    chk("rst_count",  i4.count_out, 0);
    chk("rst_valid",  i4.dec_valid_out, 0);
    chk("rst_ready",  i4.instr_ready_out, 1);
    chk("rst_opcode", i4.opcode_out, 7'h13);
    chk("rst_instr",  i4.instr_out, 25'h0);
    chk("rst_pc",     i4.pc_out, 0);
    step();
    rst_n = 1'b1;

    // First push after reset, one-cycle latency, field decode
    i4.instr_valid_in = 1'b1;
    i4.ms_riscv32_mp_instr_in = 32'h00500093;
    i4.pc_in = 32'h0;
    exp4.push_back({32'h00500093, 32'h0});
    @(negedge clk);
    chk("nobypass_valid", i4.dec_valid_out, 0);
    chk("first_ready", i4.instr_ready_out, 1);
    step();
    i4.instr_valid_in = 1'b0;
    @(negedge clk);
    chk("lat_valid",  i4.dec_valid_out, 1);
    chk("lat_opcode", i4.opcode_out, 7'h13);
    chk("lat_rd",     i4.rdaddr_out, 5'd1);
    chk("lat_csr",    i4.csr_addr_out, 12'h005);
    chk("lat_pc",     i4.pc_out, 32'h0);
    chk("lat_count",  i4.count_out, 1);
    step();
    pop4();
    @(negedge clk);
    chk("drain1_count", i4.count_out, 0);
    step();

    // Fill DEPTH=4, fifth word refused, then FIFO drain
    for (int k = 0; k < 5; k++)
      push4(32'h00208033 + (32'(k) << 7), 32'h100 + 32'(4 * k), k < 4);
    @(negedge clk);
    chk("full_count", i4.count_out, 4);
    chk("full_ready", i4.instr_ready_out, 0);
    step();
    for (int k = 0; k < 4; k++) pop4();
    @(negedge clk);
    chk("drain4_count", i4.count_out, 0);
    chk("drain4_valid", i4.dec_valid_out, 0);
    step();

    // Two entries, six cycles of simultaneous push and pop
    for (int k = 0; k < 2; k++)
      push4(32'h40000033 + (32'(k) << 15), 32'h200 + 32'(4 * k), 1'b1);
    for (int k = 2; k < 8; k++) begin
      i4.instr_valid_in = 1'b1;
      i4.dec_ready_in = 1'b1;
      i4.ms_riscv32_mp_instr_in = 32'h40000033 + (32'(k) << 15);
      i4.pc_in = 32'h200 + 32'(4 * k);
      exp4.push_back({i4.ms_riscv32_mp_instr_in, i4.pc_in});
      @(negedge clk);
      chk("pp_count", i4.count_out, 2);
      step();
    end
    i4.instr_valid_in = 1'b0;
    i4.dec_ready_in = 1'b0;
    pop4();
    pop4();

    // Flush with three entries and a competing push/pop, held two cycles
    for (int k = 0; k < 3; k++)
      push4(32'h0020a023 + (32'(k) << 20), 32'h300 + 32'(4 * k), 1'b1);
    i4.flush_in = 1'b1;
    i4.instr_valid_in = 1'b1;
    i4.dec_ready_in = 1'b1;
    i4.ms_riscv32_mp_instr_in = 32'hdeadbeef;
    i4.pc_in = 32'hbad0;
    exp4.delete();
    @(negedge clk);
    chk("flush_opcode", i4.opcode_out, 7'h13);
    chk("flush_valid",  i4.dec_valid_out, 0);
    chk("flush_pc",     i4.pc_out, 0);
    step();
    @(negedge clk);
    chk("flush2_count", i4.count_out, 0);
    chk("flush2_valid", i4.dec_valid_out, 0);
    step();
    i4.flush_in = 1'b0;
    i4.dec_ready_in = 1'b0;
    push4(32'h00c00113, 32'h400, 1'b1);
    @(negedge clk);
    chk("postflush_count", i4.count_out, 1);
    step();
    pop4();

    // Asynchronous reset mid-cycle with two entries
    push4(32'h00100193, 32'h500, 1'b1);
    push4(32'h00200213, 32'h504, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", i4.count_out, 0);
    chk("arst_valid", i4.dec_valid_out, 0);
    chk("arst_ready", i4.instr_ready_out, 1);
    exp4.delete();
    exp2.delete();
    step();
    rst_n = 1'b1;
    push4(32'h00300293, 32'h600, 1'b1);
    @(negedge clk);
    chk("postrst_count", i4.count_out, 1);
    step();
    pop4();

    // DEPTH=2: fill, then alternate pop (with refused push) and push
    push2(32'h00a00313, 32'h700);
    push2(32'h00b00393, 32'h704);
    for (int c = 0; c < 8; c++) begin
      i2.instr_valid_in = 1'b1;
      i2.ms_riscv32_mp_instr_in = 32'h01000413 + (32'(c) << 20);
      i2.pc_in = 32'h800 + 32'(4 * c);
      if (c % 2 == 0) begin
        i2.dec_ready_in = 1'b1;
      end else begin
        i2.dec_ready_in = 1'b0;
        exp2.push_back({i2.ms_riscv32_mp_instr_in, i2.pc_in});
      end
      @(negedge clk);
      chk("alt_ready", i2.instr_ready_out, (c % 2) != 0);
      chk("alt_count", i2.count_out, (c % 2 == 0) ? 2 : 1);
      step();
    end
    i2.instr_valid_in = 1'b0;
    i2.dec_ready_in = 1'b1;
    step();
    step();
    i2.dec_ready_in = 1'b0;
    @(negedge clk);
    chk("alt_final_count", i2.count_out, 0);

    chk("sb4_empty", exp4.size(), 0);
    chk("sb2_empty", exp2.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/msrv32_instr_queue.md
MSRV32_INSTR_QUEUE -- requirements
Module: msrv32_instr_queue

Interface
REQ-001 SHALL provide parameter DEPTH, default 4, queue entries; legal values are powers of 2 from 2 to 16.
REQ-002 SHALL provide parameter NOP_INSTR, default 32'h00000013 (addi x0,x0,0), the word presented while flushed or empty.
REQ-003 SHALL provide parameter PC_W, default 32, width of the PC tag carried with each instruction.
REQ-004 ms_riscv32_mp_clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-005 ms_riscv32_mp_rst_in  input  1  asynchronous, active-low reset.
REQ-006 flush_in  input  1  synchronous queue flush.
REQ-007 ms_riscv32_mp_instr_in  input  32  instruction word from instruction memory.
REQ-008 pc_in  input  PC_W  PC of ms_riscv32_mp_instr_in.
REQ-009 instr_valid_in  input  1  producer has a valid word.
REQ-010 instr_ready_out  output  1  queue accepts a word this cycle.
REQ-011 dec_valid_out  output  1  head entry valid for decode.
REQ-012 dec_ready_in  input  1  decode consumes the head this cycle.
REQ-013 opcode_out 7, funct3_out 3, funct7_out 7, rs1addr_out 5, rs2addr_out 5, rdaddr_out 5, csr_addr_out 12, instr_out 25 (bits 31:7), all outputs: fields of the presented word.
REQ-014 pc_out  output  PC_W  PC tag of the head entry.
REQ-015 count_out  output  clog2(DEPTH)+1  current number of occupied entries.

Function
REQ-016 Push SHALL occur when instr_valid_in and instr_ready_out are both 1 and flush_in is 0; the word and PC are written at the tail and the tail pointer advances.
REQ-017 Pop SHALL occur when dec_valid_out and dec_ready_in are both 1 and flush_in is 0; the head pointer advances.
REQ-018 Head and tail pointers SHALL wrap modulo DEPTH.
REQ-019 instr_ready_out SHALL be 1 exactly when count_out < DEPTH and is combinational from registered state only; a full queue SHALL NOT accept a push, even if a pop occurs in the same cycle.
REQ-020 dec_valid_out SHALL be 1 exactly when count_out > 0 and flush_in is 0.
REQ-021 Latency: a word pushed into an empty queue SHALL appear on dec_valid_out in the next cycle; there is no same-cycle bypass.
REQ-022 Simultaneous push and pop with 0 < count < DEPTH SHALL leave count_out unchanged.
REQ-023 The presented word SHALL be NOP_INSTR when flush_in is 1 or the queue is empty; otherwise it SHALL be the head entry. All field outputs are slices of the presented word: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25], csr [31:20], instr_out [31:7].
REQ-024 pc_out SHALL be the head PC when dec_valid_out is 1, and 0 otherwise.
REQ-025 flush_in SHALL, on the next edge, set the head pointer, the tail pointer and count to 0; any push or pop requested in the same cycle is discarded.
REQ-026 Consecutive flush cycles SHALL hold the queue empty; the first push is accepted in the cycle after flush_in deasserts.
REQ-027 The block SHALL NOT modify any entry other than the tail on a push.

Reset
REQ-028 Asserting ms_riscv32_mp_rst_in low SHALL immediately clear the pointers and count; outputs then read count_out=0, dec_valid_out=0, instr_ready_out=1, fields from NOP_INSTR (opcode 7'h13), and pc_out=0.
REQ-029 Reset asserted in the middle of a transfer SHALL discard all entries; storage contents need not be cleared.
REQ-030 After reset deasserts, the first edge SHALL accept a push.

Verification
REQ-031 Reset, then push 32'h00500093 with pc 0x0: next cycle dec_valid_out=1, opcode_out=7'h13, rdaddr_out=1, csr_addr_out=12'h005, pc_out=0x0, count_out=1.
REQ-032 With DEPTH=4 and dec_ready_in=0, push 5 words: count_out=4, instr_ready_out=0, the fifth word is not accepted; then pop all 4 and check FIFO order and PCs.
REQ-033 Queue holding 2 entries, simultaneous push and pop for 6 cycles: count_out stays 2, order is preserved, and the pointers wrap.
REQ-034 Queue holding 3 entries, flush_in=1 together with instr_valid_in=1 and dec_ready_in=1: in that cycle opcode_out=7'h13 and dec_valid_out=0; the next cycle count_out=0 and the pushed word is absent.
REQ-035 Queue holding 2 entries, drive ms_riscv32_mp_rst_in low asynchronously between edges: count_out=0 and dec_valid_out=0 before the next edge.
REQ-036 With DEPTH=2, fill the queue, pop 1 and push 1 alternately for 8 cycles: no lost or duplicated words and no push while full.
